// File: rtl/unsigned_int_to_double.sv
// Four-stage pipelined conversion of a 64-bit unsigned integer to IEEE-754
// binary64, round to nearest / ties to even, with a global hold (stall).
module unsigned_int_to_double (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [63:0] in_a,
  output logic        out_valid,
  output logic [63:0] out_z
);

  // S1 capture
  logic [63:0] a1_q, a1_d;
  logic        v1_q, v1_d, z1_q, z1_d;
  // S2 leading-zero count
  logic [63:0] a2_q, a2_d;
  logic [6:0]  lz2_q, lz2_d;
  logic        v2_q, v2_d, z2_q, z2_d;
  // S3 normalized value; the implicit leading one is not stored
  logic [62:0] n3_q, n3_d;
  logic [10:0] exp3_q, exp3_d;
  logic        v3_q, v3_d, z3_q, z3_d;
  // S4 result
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_z_q, out_z_d;

  logic [6:0]  lz_c;
  logic [51:0] frac_c;
  logic        guard_c, sticky_c, round_up_c;
  logic [52:0] frac_sum_c;
  logic [10:0] exp_r_c;

  always_comb begin
    lz_c = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (a1_q[i]) lz_c = 7'(63 - i);
    end
  end

  always_comb begin
    frac_c     = n3_q[62:11];
    guard_c    = n3_q[10];
    sticky_c   = |n3_q[9:0];
    round_up_c = guard_c & (sticky_c | frac_c[0]);
    // A carry out of the fraction leaves the low 52 bits at zero and bumps the exponent
    frac_sum_c = {1'b0, frac_c} + {52'b0, round_up_c};
    exp_r_c    = exp3_q + {10'b0, frac_sum_c[52]};
  end

  always_comb begin
    a1_d        = a1_q;
    v1_d        = v1_q;
    z1_d        = z1_q;
    a2_d        = a2_q;
    lz2_d       = lz2_q;
    v2_d        = v2_q;
    z2_d        = z2_q;
    n3_d        = n3_q;
    exp3_d      = exp3_q;
    v3_d        = v3_q;
    z3_d        = z3_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    if (!stall) begin
      a1_d        = in_a;
      v1_d        = in_valid;
      z1_d        = (in_a == 64'd0);
      a2_d        = a1_q;
      lz2_d       = lz_c;
      v2_d        = v1_q;
      z2_d        = z1_q;
      n3_d        = 63'(a2_q << lz2_q[5:0]);
      exp3_d      = 11'd1086 - {4'b0, lz2_q};
      v3_d        = v2_q;
      z3_d        = z2_q;
      out_valid_d = v3_q;
      // out_z only moves for valid entries so it holds between results
      if (v3_q) out_z_d = z3_q ? 64'd0 : {1'b0, exp_r_c, frac_sum_c[51:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q        <= '0;
      v1_q        <= 1'b0;
      z1_q        <= 1'b0;
      a2_q        <= '0;
      lz2_q       <= '0;
      v2_q        <= 1'b0;
      z2_q        <= 1'b0;
      n3_q        <= '0;
      exp3_q      <= '0;
      v3_q        <= 1'b0;
      z3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
    end else begin
      a1_q        <= a1_d;
      v1_q        <= v1_d;
      z1_q        <= z1_d;
      a2_q        <= a2_d;
      lz2_q       <= lz2_d;
      v2_q        <= v2_d;
      z2_q        <= z2_d;
      n3_q        <= n3_d;
      exp3_q      <= exp3_d;
      v3_q        <= v3_d;
      z3_q        <= z3_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_unsigned_int_to_double.sv
// Bench for unsigned_int_to_double: arithmetic reference model, latency-tagged
// scoreboard checked every cycle, directed literal cases, random streaming.
module tb_unsigned_int_to_double;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_a = 64'd0;
  logic        out_valid;
  logic [63:0] out_z;

  unsigned_int_to_double dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(in_valid),
    .in_a(in_a), .out_valid(out_valid), .out_z(out_z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0]     a;
    logic [63:0]     z;
    longint unsigned due;
  } ent_t;

  ent_t            q[$];
  ent_t            ent;
  logic [63:0]     seen[$];
  longint unsigned adv = 0;
  longint unsigned adv_seen = 0;
  logic            exp_valid = 1'b0;
  logic [63:0]     exp_z = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Round-to-nearest-even using integer arithmetic on the operand itself
  function automatic logic [63:0] model(input logic [63:0] a);
    int          p;
    int          e;
    int          sh;
    logic [63:0] m, rem, half;
    if (a == 64'd0) return 64'd0;
    p = 63;
    while (!a[p]) p--;
    e = 1023 + p;
    if (p <= 52) begin
      m = a << (52 - p);
    end else begin
      sh   = p - 52;
      m    = a >> sh;
      rem  = a - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 53)) begin
        m = m >> 1;
        e++;
      end
    end
    return {1'b0, 11'(e), m[51:0]};
  endfunction

  function automatic logic [63:0] decode(input logic [63:0] d);
    int          e;
    logic [63:0] m;
    if (d[62:0] == 63'd0) return 64'd0;
    e = int'(d[62:52]);
    m = {11'b0, 1'b1, d[51:0]};
    if (e >= 1075) return m << (e - 1075);
    return m >> (1075 - e);
  endfunction

  function automatic logic [63:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: r = r >> $urandom_range(0, 63);
      1: r = (64'd1 << $urandom_range(0, 63)) + 64'($urandom_range(0, 3)) - 64'd1;
      2: r = {1'b1, r[62:11], 11'b10000000000};
      3: r = r >> $urandom_range(11, 40);
      default: ;
    endcase
    return r;
  endfunction

  // Model: each accepted input is due after the third further advancing edge
  always @(posedge clk) begin
    if (rst_n && !stall) begin
      adv++;
      if (in_valid) q.push_back('{in_a, model(in_a), adv + 64'd3});
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    exp_valid = 1'b0;
    exp_z     = 64'd0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_z", out_z, 64'd0);
    end else begin
      if (adv != adv_seen) begin
        adv_seen  = adv;
        exp_valid = 1'b0;
        if (out_valid) seen.push_back(out_z);
        if (q.size() > 0 && q[0].due == adv) begin
          ent       = q.pop_front();
          exp_valid = 1'b1;
          exp_z     = ent.z;
          if (ent.a < (64'd1 << 53) && out_valid)
            chk("roundtrip", decode(out_z), ent.a);
        end
      end
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) chk("out_z", out_z, exp_z);
    end
  end

  task automatic lit(input logic [63:0] v, input logic [63:0] want, input string name);
    chk({name, "_model"}, model(v), want);
    @(posedge clk); #1;
    in_a = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk(name, out_z, want);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    lit(64'd0, 64'h0000000000000000, "zero");
    lit(64'd1, 64'h3FF0000000000000, "one");
    lit(64'd1 << 53, 64'h4340000000000000, "pow53");
    lit(64'd1 << 63, 64'h43E0000000000000, "pow63");
    lit((64'd1 << 53) + 64'd1, 64'h4340000000000000, "tie_down");
    lit((64'd1 << 53) + 64'd3, 64'h4340000000000002, "tie_up");
    lit(64'hFFFFFFFFFFFFFFFF, 64'h43F0000000000000, "max");

    // stall for three cycles after the second of 1,2,3; a value offered during stall is dropped
    repeat (4) @(posedge clk);
    seen.delete();
    @(posedge clk); #1;
    in_a = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 64'd2;
    @(posedge clk); #1;
    stall = 1'b1; in_a = 64'd99;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0; in_a = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("stall_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("stall_out0", seen[0], 64'h3FF0000000000000);
      chk("stall_out1", seen[1], 64'h4000000000000000);
      chk("stall_out2", seen[2], 64'h4008000000000000);
    end

    // bubbles: data moves but in_valid stays low
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_a = rnd();
      in_valid = 1'b0;
    end
    repeat (6) @(posedge clk);
    chk("bubble_count", 64'(seen.size()), 64'd0);

    // reset with the first entry at the output and three behind it
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_a = 64'd5 + 64'(i);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1 chk("reset_drop_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen.delete();
    lit(64'd12345, 64'h40C81C8000000000, "post_reset");
    repeat (4) @(posedge clk);
    chk("post_reset_count", 64'(seen.size()), 64'd1);

    // continuous random stream
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      in_a = rnd();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // random stalls and bubbles
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      in_a = rnd();
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    stall = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
